// File: rtl/uc_pkg.sv
// Shared definitions for the uc_seq control unit: opcode encodings,
// sequencer state encoding and the default ALU operation width.
package uc_pkg;

   // Default width of the op_alu field
   localparam int UC_ALU_W = 3;

   // Arithmetic instructions are every opcode whose MSB equals this value
   localparam logic       OP_ARITH_MSB = 1'b0;

   // Control-flow and miscellaneous opcodes
   localparam logic [5:0] OP_LI   = 6'b100000;
   localparam logic [5:0] OP_JMP  = 6'b100001;
   localparam logic [5:0] OP_JZ   = 6'b100010;
   localparam logic [5:0] OP_JNZ  = 6'b100011;
   localparam logic [5:0] OP_CALL = 6'b100100;
   localparam logic [5:0] OP_RET  = 6'b100101;
   localparam logic [5:0] OP_NOP  = 6'b100110;
   localparam logic [5:0] OP_HALT = 6'b100111;

   // Sequencer state encoding
   typedef enum logic [1:0] {
      RUN   = 2'd0,
      HALT  = 2'd1,
      FAULT = 2'd2
   } uc_state_t;

endpackage : uc_pkg

// File: rtl/uc_ret_stack.sv
// Return-address stack for call/ret.
// The stack is a circular buffer: head_reg is the next write slot and
// sp_reg counts valid entries (0..DEPTH). The top of stack is read
// combinationally and forced to 0 when the stack is empty.
// Build option UC_STACK_WRAP_EN: a push on a full stack overwrites the
// oldest entry (head wraps, sp stays DEPTH) instead of being dropped.
module uc_ret_stack #(
   parameter int PC_W  = 10,
   parameter int DEPTH = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            push,
   input  logic            pop,
   input  logic [PC_W-1:0] din,
   output logic [PC_W-1:0] top,
   output logic            full,
   output logic            empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int SP_W  = PTR_W + 1;

   logic [PC_W-1:0]  mem [DEPTH];
   logic [PTR_W-1:0] head_reg;
   logic [SP_W-1:0]  sp_reg;
   logic [PTR_W-1:0] top_idx;
   logic             do_push;
   logic             do_pop;

   assign full  = (sp_reg == SP_W'(DEPTH));
   assign empty = (sp_reg == '0);

`ifdef UC_STACK_WRAP_EN
   assign do_push = push;
`else
   assign do_push = push && !full;
`endif
   // An empty-stack pop is ignored; the sequencer turns it into a fault
   assign do_pop  = pop && !push && !empty;

   // Head index and occupancy; DEPTH is a power of two so the head wraps naturally
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_reg <= '0;
         sp_reg   <= '0;
      end else if (do_push) begin
         head_reg <= head_reg + PTR_W'(1);
         if (!full)
            sp_reg <= sp_reg + SP_W'(1);
      end else if (do_pop) begin
         head_reg <= head_reg - PTR_W'(1);
         sp_reg   <= sp_reg - SP_W'(1);
      end
   end

   // Entry storage; contents are don't-care after reset
   always_ff @(posedge clk) begin
      if (do_push)
         mem[head_reg] <= din;
   end

   // Combinational top-of-stack, 0 when nothing has been pushed
   always_comb begin
      top_idx = head_reg - PTR_W'(1);
      top     = empty ? '0 : mem[top_idx];
   end

endmodule : uc_ret_stack

// File: rtl/uc_seq.sv
// uc_seq: instruction decoder and sequencer for the CPU datapath.
// Decodes the 6-bit opcode into PC/register-file mux controls, holds the
// registered zero flag, a return-address stack, and RUN/HALT/FAULT state.
// Build option UC_STACK_WRAP_EN: call on a full stack overwrites the
// oldest return address instead of faulting.
module uc_seq
   import uc_pkg::*;
#(
   parameter int PC_W  = 10,
   parameter int DEPTH = 8,
   parameter int ALU_W = UC_ALU_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic             z_alu,
   input  logic [PC_W-1:0]  pc_next,
   output logic             s_inc,
   output logic             s_inm,
   output logic             we3,
   output logic             wez,
   output logic             s_pila,
   output logic [ALU_W-1:0] op_alu,
   output logic [PC_W-1:0]  ret_addr,
   output logic             stack_full,
   output logic             stack_empty,
   output logic             halted,
   output logic             fault
);

   uc_state_t state_reg;
   uc_state_t state_next;
   logic      z_q_reg;
   logic      push_req;
   logic      pop_req;

   uc_ret_stack #(
      .PC_W  (PC_W),
      .DEPTH (DEPTH)
   ) u_ret_stack (
      .clk   (clk),
      .reset (reset),
      .push  (push_req),
      .pop   (pop_req),
      .din   (pc_next),
      .top   (ret_addr),
      .full  (stack_full),
      .empty (stack_empty)
   );

   // State register; HALT and FAULT are left only through reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state_reg <= RUN;
      else
         state_reg <= state_next;
   end

   // Next state: halt instruction, call on full stack, ret on empty stack
   always_comb begin
      state_next = state_reg;
      if (state_reg == RUN) begin
         case (opcode)
            OP_HALT: state_next = HALT;
            OP_CALL: begin
`ifndef UC_STACK_WRAP_EN
               if (stack_full)
                  state_next = FAULT;
`endif
            end
            OP_RET: begin
               if (stack_empty)
                  state_next = FAULT;
            end
            default: state_next = state_reg;
         endcase
      end
   end

   // Datapath controls; everything stays 0 outside RUN and while reset is held
   always_comb begin
      s_inc    = 1'b0;
      s_inm    = 1'b0;
      we3      = 1'b0;
      wez      = 1'b0;
      s_pila   = 1'b0;
      op_alu   = '0;
      push_req = 1'b0;
      pop_req  = 1'b0;
      if (reset && (state_reg == RUN)) begin
         if (opcode[5] == OP_ARITH_MSB) begin
            op_alu = ALU_W'(opcode[4:2]);
            we3    = 1'b1;
            wez    = 1'b1;
            s_inc  = 1'b1;
         end else begin
            case (opcode)
               OP_LI: begin
                  s_inm = 1'b1;
                  we3   = 1'b1;
                  s_inc = 1'b1;
               end
               OP_JMP:  s_inc = 1'b0;
               OP_JZ:   s_inc = ~z_q_reg;
               OP_JNZ:  s_inc = z_q_reg;
               OP_CALL: push_req = 1'b1;
               OP_RET: begin
                  // ret_addr is 0 on an empty stack, so PC loads 0 as it faults
                  s_pila  = 1'b1;
                  pop_req = 1'b1;
               end
               OP_NOP:  s_inc = 1'b1;
               OP_HALT: s_inc = 1'b0;
               // Undefined opcodes behave as nop
               default: s_inc = 1'b1;
            endcase
         end
      end
   end

   // Zero flag captures the ALU result only on flag-writing instructions
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         z_q_reg <= 1'b0;
      else if (wez)
         z_q_reg <= z_alu;
   end

   assign halted = (state_reg == HALT);
   assign fault  = (state_reg == FAULT);

endmodule : uc_seq
